// File: rtl/sample_buffer_pkg.sv
// rtl/sample_buffer_pkg.sv - shared defaults and state encoding for the capture buffer
package sample_buffer_pkg;

    localparam int DEF_SAMPLE_WIDTH = 8;
    localparam int DEF_DEPTH_LOG2   = 10;

    // Encoding is decoded by host-side status readers; keep values stable.
    typedef enum logic [2:0] {
        ST_FILL    = 3'd0,
        ST_PRIMED  = 3'd1,
        ST_FROZEN  = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/sample_buffer_if.sv
// rtl/sample_buffer_if.sv - readout control and sample stream between buffer and consumer
interface sample_buffer_if
    import sample_buffer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
);
    logic                    i_rd_start;
    logic                    o_valid;
    logic                    i_ready;
    logic [SAMPLE_WIDTH-1:0] o_data;
    logic                    o_last;
    logic                    o_done;

    modport master (
        input  i_rd_start, i_ready,
        output o_valid, o_data, o_last, o_done
    );

    modport slave (
        output i_rd_start, i_ready,
        input  o_valid, o_data, o_last, o_done
    );
endinterface

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port capture RAM, synchronous read with one cycle latency
module sample_ram
    import sample_buffer_pkg::*;
#(
    parameter int WIDTH      = DEF_SAMPLE_WIDTH,
    parameter int ADDR_WIDTH = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);
    logic [WIDTH-1:0] r_mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/sample_buffer.sv
// rtl/sample_buffer.sv - circular capture buffer: fill, freeze on stop, stream window oldest-first
module sample_buffer
    import sample_buffer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_stopped,
    output logic                    o_primed,
    output logic                    o_frozen,
    sample_buffer_if.master         rd
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LAST_IDX = (DEPTH_LOG2 + 1)'(DEPTH - 1);

    state_e r_state;
    state_e w_state_next;

    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]     r_fill_cnt;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_issue_cnt;
    logic [DEPTH_LOG2:0]     r_beat_cnt;
    logic                    r_inflight;
    logic                    r_inflight_last;
    logic [1:0]              r_q_cnt;
    logic [SAMPLE_WIDTH-1:0] r_q_data [2];
    logic [1:0]              r_q_last;

    logic                    w_we;
    logic                    w_readout;
    logic                    w_start;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_push;
    logic [DEPTH_LOG2-1:0]   w_rd_addr;
    logic [DEPTH_LOG2:0]     w_issue_idx;
    logic [SAMPLE_WIDTH-1:0] w_rdata;
    logic [2:0]              w_credit;

    sample_ram #(
        .WIDTH      (SAMPLE_WIDTH),
        .ADDR_WIDTH (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_sample),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:    if (r_fill_cnt == LAST_IDX)             w_state_next = ST_PRIMED;
            ST_PRIMED:  if (i_stopped)                          w_state_next = ST_FROZEN;
            ST_FROZEN:  if (rd.i_rd_start)                      w_state_next = ST_READOUT;
            ST_READOUT: if (w_pop && r_beat_cnt == LAST_IDX)    w_state_next = ST_DONE;
            ST_DONE:                                            w_state_next = ST_DONE;
            default:                                            w_state_next = ST_FILL;
        endcase
    end

    always_comb begin
        w_we      = 1'b0;
        w_readout = 1'b0;
        o_primed  = 1'b0;
        o_frozen  = 1'b0;
        rd.o_done = 1'b0;
        case (r_state)
            ST_FILL:    w_we = 1'b1;
            ST_PRIMED:  begin o_primed = 1'b1; w_we = !i_stopped; end
            ST_FROZEN:  begin o_primed = 1'b1; o_frozen = 1'b1; end
            ST_READOUT: begin o_primed = 1'b1; o_frozen = 1'b1; w_readout = 1'b1; end
            ST_DONE:    begin o_primed = 1'b1; o_frozen = 1'b1; rd.o_done = 1'b1; end
            default:    w_we = 1'b0;
        endcase
    end

    assign rd.o_valid = (r_q_cnt != 2'd0);
    assign rd.o_data  = r_q_data[0];
    assign rd.o_last  = r_q_last[0] && rd.o_valid;

    assign w_start = (r_state == ST_FROZEN) && rd.i_rd_start;
    assign w_pop   = rd.o_valid && rd.i_ready;
    assign w_push  = r_inflight;

    // Queue plus in-flight read, less the beat leaving now, must leave a slot for one more read.
    assign w_credit    = {1'b0, r_q_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = w_start || (w_readout && !r_issue_cnt[DEPTH_LOG2] && w_credit <= 3'd1);
    assign w_rd_addr   = w_start ? r_wr_ptr : r_rd_ptr;
    assign w_issue_idx = w_start ? '0 : r_issue_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr        <= '0;
            r_fill_cnt      <= '0;
            r_rd_ptr        <= '0;
            r_issue_cnt     <= '0;
            r_beat_cnt      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (r_state == ST_FILL) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr        <= w_rd_addr + 1'b1;
                r_issue_cnt     <= w_issue_idx + 1'b1;
                r_inflight_last <= (w_issue_idx == LAST_IDX);
            end
            r_inflight <= w_issue;
            if (w_start) begin
                r_beat_cnt <= '0;
            end else if (w_pop) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Two-entry skid queue; entry 0 is the head presented on the stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q_cnt     <= 2'd0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_last    <= 2'b00;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_q_cnt == 2'd0) begin
                        r_q_data[0] <= w_rdata;
                        r_q_last[0] <= r_inflight_last;
                    end else begin
                        r_q_data[1] <= w_rdata;
                        r_q_last[1] <= r_inflight_last;
                    end
                    r_q_cnt <= r_q_cnt + 2'd1;
                end
                2'b01: begin
                    r_q_data[0] <= r_q_data[1];
                    r_q_last[0] <= r_q_last[1];
                    r_q_cnt     <= r_q_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_q_cnt == 2'd1) begin
                        r_q_data[0] <= w_rdata;
                        r_q_last[0] <= r_inflight_last;
                    end else begin
                        r_q_data[0] <= r_q_data[1];
                        r_q_last[0] <= r_q_last[1];
                        r_q_data[1] <= w_rdata;
                        r_q_last[1] <= r_inflight_last;
                    end
                end
                default: r_q_cnt <= r_q_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_buffer.sv
// tb/tb_sample_buffer.sv - randomized self-checking bench for sample_buffer against a window model
module tb_sample_buffer;
    localparam int SW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] i_sample;
    logic          i_stopped;
    logic          o_primed;
    logic          o_frozen;

    sample_buffer_if #(.SAMPLE_WIDTH(SW)) rd_if ();

    sample_buffer #(
        .SAMPLE_WIDTH (SW),
        .DEPTH_LOG2   (DL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_sample  (i_sample),
        .i_stopped (i_stopped),
        .o_primed  (o_primed),
        .o_frozen  (o_frozen),
        .rd        (rd_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int m_written;
    bit m_frozen;
    logic [SW-1:0] hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: a sample is stored unless the window is already full and stop is requested,
    // in which case capture freezes for good.
    task automatic step();
        @(posedge clk);
        if (!m_frozen) begin
            if (m_written < DEPTH || !i_stopped) begin
                hist.push_back(i_sample);
                m_written++;
            end else begin
                m_frozen = 1'b1;
            end
        end
        #1;
        cyc++;
        i_sample = SW'(cyc);
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        i_stopped        = 1'b0;
        rd_if.i_rd_start = 1'b0;
        rd_if.i_ready    = 1'b0;
        i_sample         = '0;
        repeat (2) @(posedge clk);
        #1;
        m_written = 0;
        m_frozen  = 1'b0;
        hist.delete();
        check("rst_primed", o_primed, 0);
        check("rst_frozen", o_frozen, 0);
        check("rst_valid", rd_if.o_valid, 0);
        check("rst_done", rd_if.o_done, 0);
        check("rst_last", rd_if.o_last, 0);
        @(negedge clk);
        reset    = 1'b1;
        cyc      = 0;
        i_sample = '0;
    endtask

    task automatic capture(input int stop_at, input bit early, input bit rnd_start, input int limit);
        while (!m_frozen && cyc < limit) begin
            i_stopped = (cyc >= stop_at) || (early && cyc >= 5 && cyc < 8);
            rd_if.i_rd_start = rnd_start ? ($urandom_range(0, 4) == 0) : (cyc == 3 || cyc == 25);
            step();
            check("primed", o_primed, (m_written >= DEPTH));
            check("frozen", o_frozen, m_frozen);
            check("cap_valid", rd_if.o_valid, 0);
        end
        rd_if.i_rd_start = 1'b0;
    endtask

    // mode 0: ready held high, 1: ready toggles, 2: random ready
    task automatic readout(input int mode, input int max_beats);
        logic [SW-1:0] exp_win [DEPTH];
        logic [SW-1:0] held_d;
        logic          held_l;
        bit            stalled;
        int            beat;
        int            t;
        stalled = 1'b0;
        beat    = 0;
        t       = 0;
        held_d  = '0;
        held_l  = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_win[i] = hist[hist.size() - DEPTH + i];
        repeat (2) begin
            step();
            check("frozen_valid", rd_if.o_valid, 0);
        end
        rd_if.i_rd_start = 1'b1;
        rd_if.i_ready    = (mode == 0);
        step();
        rd_if.i_rd_start = 1'b0;
        check("lat1_valid", rd_if.o_valid, 0);
        step();
        check("lat2_valid", rd_if.o_valid, 1);
        while (beat < max_beats && t < 200) begin
            case (mode)
                0:       rd_if.i_ready = 1'b1;
                1:       rd_if.i_ready = (t % 2 == 0);
                default: rd_if.i_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 0) check("no_bubble", rd_if.o_valid, 1);
            check("early_done", rd_if.o_done, 0);
            if (stalled) begin
                check("stall_valid", rd_if.o_valid, 1);
                check("stall_data", rd_if.o_data, held_d);
                check("stall_last", rd_if.o_last, held_l);
            end
            if (rd_if.o_valid) begin
                if (rd_if.i_ready) begin
                    check("data", rd_if.o_data, exp_win[beat]);
                    check("last", rd_if.o_last, (beat == DEPTH - 1));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = rd_if.o_data;
                    held_l  = rd_if.o_last;
                end
            end
            step();
            t++;
        end
        check("beats", beat, max_beats);
        if (max_beats == DEPTH) begin
            check("done", rd_if.o_done, 1);
            check("done_valid", rd_if.o_valid, 0);
            repeat (2) step();
            check("done_hold", rd_if.o_done, 1);
            check("done_primed", o_primed, 1);
        end
    endtask

    initial begin
        do_reset();
        capture(40, 1'b1, 1'b0, 500);
        readout(0, DEPTH);

        do_reset();
        capture(40, 1'b0, 1'b0, 500);
        readout(1, DEPTH);

        repeat (3) begin
            do_reset();
            capture(int'($urandom_range(16, 90)), 1'b0, 1'b1, 500);
            readout(2, DEPTH);
        end

        do_reset();
        capture(40, 1'b0, 1'b0, 500);
        readout(0, 7);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", rd_if.o_valid, 0);
        check("async_frozen", o_frozen, 0);
        check("async_primed", o_primed, 0);
        check("async_done", rd_if.o_done, 0);
        do_reset();
        capture(1000, 1'b0, 1'b0, 20);
        check("refill_primed", o_primed, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
